lif_neuron: RTL
===============

// Module: lif_neuron
// PURPOSE
//  Leaky integrate-and-fire neuron stage that sits directly downstream of the 5-input spike MAC.
//  Each accepted MAC weighted sum (one per timestep) is added to a membrane potential, then a leak is subtracted.
//  When the potential reaches the threshold, the neuron emits a one-cycle output spike, resets the potential
//  and enters a refractory period. The output spike drives the next layer's pixel/spike input.
// PARAMETERS
//  IN_WIDTH  8    width of sum_in (matches MAC sum width)
//  V_WIDTH   12   membrane potential width, unsigned
//  V_RESET   0    potential loaded after a fire
//  REFRACT   2    refractory length in accepted timesteps (0 = none)
//  CNT_WIDTH 16   spike counter width
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          async active-low reset
//  clr        in   1          sync clear of neuron state; has priority over everything except rst_n
//  sum_in     in   IN_WIDTH   weighted spike sum from MAC, unsigned
//  in_valid   in   1          sum_in valid this cycle
//  in_ready   out  1          stage can accept; a transfer occurs when in_valid && in_ready
//  thresh     in   V_WIDTH    firing threshold, sampled on each transfer
//  leak       in   8          per-timestep leak, sampled on each transfer
//  spike      out  1          registered one-cycle fire pulse
//  vmem       out  V_WIDTH    current membrane potential (register)
//  spike_cnt  out  CNT_WIDTH  total fires since reset/clr, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): state=INTEG, vmem=0, spike=0, refr_cnt=0, spike_cnt=0.
//  clr=1 at edge: same values as reset; any input present that cycle is dropped.
//  in_ready is decoded from state: 1 in INTEG and REFR, 0 in FIRE.
//  INTEG, on transfer:
//   s = min(vmem + sum_in, 2^V_WIDTH-1) (saturating add)
//   v = (s > leak) ? s - leak : 0 (floor at 0)
//   v >= thresh -> vmem<=v, spike<=1, state<=FIRE
//   else -> vmem<=v, state stays INTEG
//  INTEG, no transfer: vmem held (leak is applied per timestep, not per cycle).
//  FIRE (exactly 1 cycle): spike=1 is visible; in_ready=0
//   next edge: vmem<=V_RESET, spike<=0
//   REFRACT>0 -> refr_cnt<=REFRACT, state<=REFR; else state<=INTEG
//  REFR, on transfer: input is consumed and discarded, vmem unchanged, refr_cnt decrements
//   when refr_cnt reaches 1 on a transfer, state<=INTEG
//   no transfer: hold
//  spike_cnt increments on the INTEG->FIRE edge; it saturates at all-ones.
//  Latency: transfer to spike high = 1 cycle; a spike is never longer than 1 cycle.
//  A fire triggered by thresh=0 is legal: any transfer fires.
//  rst_n deasserted mid-FIRE/REFR: returns to INTEG with vmem=0 and no residual spike.
// TESTING
//  T1: thresh=100, leak=2, sums 50,50,10 -> vmem 48,96; third transfer spike=1 next cycle, then vmem=0, spike_cnt=1
//  T2: REFRACT=2, after T1 fire feed 200,200 -> both discarded, vmem stays 0, in_ready=0 only in FIRE cycle; then 60 -> vmem=58
//  T3: sum 1, leak 5 from vmem=0 -> vmem=0 (floor); sum 0 with leak 0 -> vmem unchanged
//  T4: thresh=4095, leak=0, seventeen sums of 255 -> 16th gives 4080, 17th saturates at 4095 and fires
//  T5: in_valid toggled randomly with idle gaps -> vmem changes only on transfers; spike count matches a golden model
//  T6: rst_n and then clr asserted during FIRE and during REFR -> all outputs return to reset values; next transfer integrates from 0

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates one MAC sum per accepted timestep,
// fires a one-cycle spike at threshold, then sits out a refractory period.
module lif_neuron #(
  parameter int IN_WIDTH  = 8,
  parameter int V_WIDTH   = 12,
  parameter int V_RESET   = 0,
  parameter int REFRACT   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [IN_WIDTH-1:0]  sum_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [V_WIDTH-1:0]   thresh,
  input  logic [7:0]           leak,
  output logic                 spike,
  output logic [V_WIDTH-1:0]   vmem,
  output logic [CNT_WIDTH-1:0] spike_cnt
);

  localparam int RC_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  typedef enum logic [1:0] {
    INTEG = 2'd0,
    FIRE  = 2'd1,
    REFR  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [V_WIDTH-1:0]   vmem_n;
  logic                 spike_n;
  logic [RC_W-1:0]      refr_cnt, refr_n;
  logic [CNT_WIDTH-1:0] cnt_n;

  logic                 xfer;
  logic [V_WIDTH:0]     sum_ext;
  logic [V_WIDTH-1:0]   s_sat;
  logic [V_WIDTH-1:0]   leak_ext;
  logic [V_WIDTH-1:0]   v_leak;

  // Handshake: a timestep transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, so the producer never sees a combinational loop.
  assign in_ready = (state != FIRE);
  assign xfer     = in_valid && in_ready;

  assign sum_ext  = {1'b0, vmem} + {{(V_WIDTH + 1 - IN_WIDTH){1'b0}}, sum_in};
  assign s_sat    = sum_ext[V_WIDTH] ? {V_WIDTH{1'b1}} : sum_ext[V_WIDTH-1:0];
  assign leak_ext = {{(V_WIDTH - 8){1'b0}}, leak};
  assign v_leak   = (s_sat > leak_ext) ? (s_sat - leak_ext) : '0;

  always_comb begin
    state_n = state;
    vmem_n  = vmem;
    spike_n = 1'b0;
    refr_n  = refr_cnt;
    cnt_n   = spike_cnt;
    unique case (state)
      INTEG: begin
        if (xfer) begin
          vmem_n = v_leak;
          if (v_leak >= thresh) begin
            spike_n = 1'b1;
            state_n = FIRE;
            cnt_n   = (spike_cnt == {CNT_WIDTH{1'b1}}) ? spike_cnt
                                                       : spike_cnt + CNT_WIDTH'(1);
          end
        end
      end
      FIRE: begin
        vmem_n = V_WIDTH'(V_RESET);
        if (REFRACT > 0) begin
          refr_n  = RC_W'(REFRACT);
          state_n = REFR;
        end else begin
          state_n = INTEG;
        end
      end
      REFR: begin
        // Input is consumed during refractory but never integrated.
        if (xfer) begin
          if (refr_cnt <= RC_W'(1)) begin
            refr_n  = '0;
            state_n = INTEG;
          end else begin
            refr_n = refr_cnt - RC_W'(1);
          end
        end
      end
      default: state_n = INTEG;
    endcase
    if (clr) begin
      state_n = INTEG;
      vmem_n  = '0;
      spike_n = 1'b0;
      refr_n  = '0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INTEG;
      vmem      <= '0;
      spike     <= 1'b0;
      refr_cnt  <= '0;
      spike_cnt <= '0;
    end else begin
      state     <= state_n;
      vmem      <= vmem_n;
      spike     <= spike_n;
      refr_cnt  <= refr_n;
      spike_cnt <= cnt_n;
    end
  end

endmodule
